bus_ram_responder: RTL and testbench

//  Responder (slave) end of the core's bus master protocol: a word-addressed, byte-maskable RAM

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_ram_responder_ram_bank.sv | 41 ++++
 rtl/bus_ram_responder.sv | 156 +++++++++++++++
 tb/tb_bus_ram_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the core's master protocol and its responders.
//   rsp_state_e : responder FSM states
//   BUS_WORD_W  : data word width
//   BUS_MASK_W  : byte-enable width
//   bus_req_s   : one captured bus request
package bus_pkg;

    localparam int BUS_WORD_W = 32;
    localparam int BUS_MASK_W = 4;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_RESP
    } rsp_state_e;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [BUS_WORD_W-1:0] wdata;
        logic [BUS_MASK_W-1:0] mask;
    } bus_req_s;

endpackage

// File: rtl/bus_ram_responder_ram_bank.sv
// ram_bank: byte-enabled synchronous single-port RAM, DEPTH x 32.
// No reset. The read is registered, and rdata holds its value until the next read.
// Ports:
//   clk   in  clock
//   en    in  access strobe for this edge
//   we    in  1=write, 0=read
//   idx   in  word index
//   wdata in  write data
//   mask  in  per-byte write enables
//   rdata out registered read data
module ram_bank
    import bus_pkg::*;
#(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [BUS_WORD_W-1:0]    wdata,
    input  logic [BUS_MASK_W-1:0]    mask,
    output logic [BUS_WORD_W-1:0]    rdata
);

    logic [BUS_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BUS_MASK_W; i++) begin
                    if (mask[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/bus_ram_responder.sv
// bus_ram_responder: responder end of the core bus. It is a word-addressed, byte-maskable RAM
// with a configurable number of wait states.
// Optional feature macro: BUS_RAM_RANGE_CHK_EN. When it is defined, an access whose
// (req_addr - BASE_WORD) is >= DEPTH completes with rsp_err=1 and leaves the RAM untouched.
// When it is not defined, such an access aliases modulo DEPTH and rsp_err stays 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_en      request valid
//   req_we      1=write, 0=read
//   req_addr    word address
//   req_wdata   write data
//   req_mask    byte write enables
//   rsp_rdata   read data (0 after write/error responses)
//   rsp_valid   one-cycle completion pulse
//   rsp_stall   master holds req_* while high
//   rsp_err     completion failed (qualifies rsp_valid)
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter int          AW          = 30,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 0,
    parameter int unsigned BASE_WORD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_en,
    input  logic                  req_we,
    input  logic [AW-1:0]         req_addr,
    input  logic [BUS_WORD_W-1:0] req_wdata,
    input  logic [BUS_MASK_W-1:0] req_mask,
    output logic [BUS_WORD_W-1:0] rsp_rdata,
    output logic                  rsp_valid,
    output logic                  rsp_stall,
    output logic                  rsp_err
);

    localparam int       IW       = $clog2(DEPTH);
    // With 0 or 1 wait states, the RAM is accessed on the accept edge itself.
    // Otherwise it is accessed from the capture register on the last WAIT edge.
    localparam bit       USE_CAP  = (WAIT_STATES >= 2);
    localparam bit [3:0] CNT_LAST = 4'(WAIT_STATES - 1);

    rsp_state_e            state;
    logic [3:0]            cnt;
    bus_req_s              cap;
    logic                  valid_q;
    logic                  err_q;
    logic                  zero_q;
    logic [BUS_WORD_W-1:0] ram_q;

    logic                  take;
    logic                  acc_now;
    logic                  acc_we;
    logic                  acc_err;
    logic [AW-1:0]         live_off;
    logic [AW-1:0]         cap_off;
    logic [AW-1:0]         acc_off;
    logic [BUS_WORD_W-1:0] acc_wdata;
    logic [BUS_MASK_W-1:0] acc_mask;

    // A request is taken whenever the responder is not counting wait states.
    // This includes the response cycle of the previous access.
    assign take     = rst_n && req_en && (state != RSP_WAIT);
    assign live_off = req_addr - AW'(BASE_WORD);
    assign cap_off  = AW'(cap.addr - 32'(BASE_WORD));

    always_comb begin
        if (USE_CAP) begin
            acc_now   = (state == RSP_WAIT) && (cnt == CNT_LAST);
            acc_we    = cap.we;
            acc_off   = cap_off;
            acc_wdata = cap.wdata;
            acc_mask  = cap.mask;
        end else begin
            acc_now   = take;
            acc_we    = req_we;
            acc_off   = live_off;
            acc_wdata = req_wdata;
            acc_mask  = req_mask;
        end
    end

`ifdef BUS_RAM_RANGE_CHK_EN
    assign acc_err = (32'(acc_off) >= 32'(DEPTH));
`else
    assign acc_err = 1'b0;
`endif

    ram_bank #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (acc_now && !acc_err),
        .we    (acc_we),
        .idx   (acc_off[IW-1:0]),
        .wdata (acc_wdata),
        .mask  (acc_mask),
        .rdata (ram_q)
    );

    // The request payload is data. It is not reset; it is only loaded on take.
    always_ff @(posedge clk) begin
        if (take) begin
            cap <= '{addr: 32'(req_addr), we: req_we, wdata: req_wdata, mask: req_mask};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RSP_IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            valid_q <= acc_now;
            err_q   <= acc_now && acc_err;
            // zero_q chooses between 0 and the RAM read register.
            // Because it changes only on a completed access, rdata holds between responses.
            if (acc_now) begin
                zero_q <= acc_we || acc_err;
            end
            case (state)
                RSP_IDLE, RSP_RESP: begin
                    if (take) begin
                        if (USE_CAP) begin
                            state <= RSP_WAIT;
                            // The accept cycle counts as the first stall cycle.
                            cnt   <= 4'd1;
                        end else begin
                            state <= RSP_RESP;
                        end
                    end else begin
                        state <= RSP_IDLE;
                    end
                end
                RSP_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= RSP_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= RSP_IDLE;
            endcase
        end
    end

    assign rsp_stall = (WAIT_STATES > 0) && (take || (state == RSP_WAIT));
    assign rsp_valid = valid_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder. It instantiates two responders: one with no wait states, and one
// with three wait states and a non-zero base word. A transaction-level model, built from
// accept time, latency and a word array, predicts every output on every cycle.
module tb_bus_ram_responder;

    localparam int AW    = 30;
    localparam int DEPTH = 4096;
    localparam int BASE3 = 'h100;
`ifdef BUS_RAM_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic          req_en    [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [31:0]   req_wdata [2];
    logic [3:0]    req_mask  [2];
    logic [31:0]   rsp_rdata [2];
    logic          rsp_valid [2];
    logic          rsp_stall [2];
    logic          rsp_err   [2];

    int cyc       = 0;
    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bus_ram_responder #(.AW(AW), .DEPTH(DEPTH), .WAIT_STATES(0), .BASE_WORD(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_en(req_en[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_mask(req_mask[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_valid(rsp_valid[0]), .rsp_stall(rsp_stall[0]),
        .rsp_err(rsp_err[0])
    );

    bus_ram_responder #(.AW(AW), .DEPTH(DEPTH), .WAIT_STATES(3), .BASE_WORD(BASE3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req_en(req_en[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_mask(req_mask[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_valid(rsp_valid[1]), .rsp_stall(rsp_stall[1]),
        .rsp_err(rsp_err[1])
    );

    function automatic int waitof(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int latof(input int d);
        return (waitof(d) > 1) ? waitof(d) : 1;
    endfunction

    function automatic int baseof(input int d);
        return (d == 0) ? 0 : BASE3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %b required %b", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mm        [2][DEPTH];
    bit          pend      [2];
    int          pend_due  [2];
    bit          pend_we   [2];
    bit          pend_err  [2];
    int          pend_idx  [2];
    logic [31:0] pend_wd   [2];
    logic [3:0]  pend_mask [2];
    int          next_free [2];
    int          stall_end [2];
    logic [31:0] last_rd   [2];
    bit          m_valid, m_err, m_stall;
    int          m_idx;
    bit          m_rerr;
    logic [AW-1:0] m_off;

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; next_free[d] = 0; stall_end[d] = 0; last_rd[d] = '0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_valid = 1'b0; m_err = 1'b0; m_stall = 1'b0;
            if (!rst_n) begin
                pend[d] = 1'b0; next_free[d] = 0; stall_end[d] = 0; last_rd[d] = '0;
            end else begin
                if (pend[d] && pend_due[d] == cyc) begin
                    m_valid = 1'b1;
                    m_err   = pend_err[d];
                    pend[d] = 1'b0;
                    if (pend_we[d] || pend_err[d]) last_rd[d] = '0;
                    else last_rd[d] = mm[d][pend_idx[d]];
                    if (pend_we[d] && !pend_err[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (pend_mask[d][b]) mm[d][pend_idx[d]][8*b +: 8] = pend_wd[d][8*b +: 8];
                        end
                    end
                end
                if (req_en[d] && cyc >= next_free[d]) begin
                    m_off        = req_addr[d] - AW'(baseof(d));
                    m_idx        = int'(m_off) % DEPTH;
                    m_rerr       = RCHK && (int'(m_off) >= DEPTH);
                    pend[d]      = 1'b1;
                    pend_due[d]  = cyc + latof(d);
                    pend_we[d]   = req_we[d];
                    pend_err[d]  = m_rerr;
                    pend_idx[d]  = m_idx;
                    pend_wd[d]   = req_wdata[d];
                    pend_mask[d] = req_mask[d];
                    next_free[d] = cyc + latof(d);
                    stall_end[d] = cyc + waitof(d);
                end
                m_stall = (cyc < stall_end[d]);
            end
            chk1($sformatf("valid[%0d]@%0d", d, cyc), rsp_valid[d], m_valid);
            chk1($sformatf("err[%0d]@%0d", d, cyc), rsp_err[d], m_err);
            chk1($sformatf("stall[%0d]@%0d", d, cyc), rsp_stall[d], m_stall);
            chk($sformatf("rdata[%0d]@%0d", d, cyc), rsp_rdata[d], last_rd[d]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [3:0] mask);
        req_en[d]    = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        req_mask[d]  = mask;
    endtask

    // Called at posedge+1; holds the request for its full latency, returns at posedge+1
    // of the response cycle with req_en dropped (the caller may immediately issue again).
    task automatic issue(input int d, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [3:0] mask);
        drive(d, we, addr, wd, mask);
        repeat (latof(d)) @(posedge clk);
        #1 req_en[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            int          idx;
            int          alias_off;
            logic [AW-1:0] a;
            idx       = int'($urandom_range(0, 15));
            alias_off = ($urandom_range(0, 3) == 0) ? DEPTH : 0;
            a         = AW'(baseof(d) + idx + alias_off);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            issue(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_en[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_mask[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_valid0", rsp_valid[0], 1'b0);
        chk1("reset_stall3", rsp_stall[1], 1'b0);
        chk("reset_rdata3", rsp_rdata[1], 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-word write then read with no wait states
        issue(0, 1'b1, AW'(32'h10), 32'hDEADBEEF, 4'hF);
        chk1("t1_wr_valid", rsp_valid[0], 1'b1);
        chk("t1_wr_rdata", rsp_rdata[0], 32'h0);
        issue(0, 1'b0, AW'(32'h10), 32'h0, 4'h0);
        chk1("t1_rd_valid", rsp_valid[0], 1'b1);
        chk("t1_rd_rdata", rsp_rdata[0], 32'hDEADBEEF);

        // Byte-masked write
        issue(0, 1'b1, AW'(32'h20), 32'h11223344, 4'hF);
        issue(0, 1'b1, AW'(32'h20), 32'hAABBCCDD, 4'b0101);
        issue(0, 0, AW'(32'h20), 32'h0, 4'h0);
        chk("t2_mask_rdata", rsp_rdata[0], 32'h11BB33DD);

        // Three wait states, back-to-back held requests
        issue(1, 1'b1, AW'(BASE3 + 5), 32'h55AA00FF, 4'hF);
        drive(1, 1'b0, AW'(BASE3 + 5), 32'h0, 4'h0);
        #1 chk1("t3_stall_accept", rsp_stall[1], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk1("t3_valid_first", rsp_valid[1], 1'b1);
        chk("t3_rdata_first", rsp_rdata[1], 32'h55AA00FF);
        drive(1, 1'b0, AW'(BASE3 + 5), 32'h0, 4'h0);
        #1 chk1("t3_stall_second", rsp_stall[1], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk1("t3_valid_second", rsp_valid[1], 1'b1);
        chk("t3_rdata_second", rsp_rdata[1], 32'h55AA00FF);
        req_en[1] = 1'b0;

        // Eight back-to-back reads
        for (int i = 0; i < 8; i++) issue(0, 1'b1, AW'(48 + i), 32'hC0DE0000 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) begin
            issue(0, 1'b0, AW'(48 + i), 32'h0, 4'h0);
            chk($sformatf("t4_rd%0d", i), rsp_rdata[0], 32'hC0DE0000 + 32'(i));
        end

        // Out-of-range word 4096
        issue(0, 1'b1, AW'(0), 32'h12345678, 4'hF);
        issue(0, 1'b1, AW'(4096), 32'hFFFFFFFF, 4'hF);
        chk1("t5_valid", rsp_valid[0], 1'b1);
        chk1("t5_err", rsp_err[0], RCHK);
        chk("t5_rdata", rsp_rdata[0], 32'h0);
        issue(0, 1'b0, AW'(0), 32'h0, 4'h0);
        chk("t5_word0", rsp_rdata[0], RCHK ? 32'h12345678 : 32'hFFFFFFFF);

        // Reset during a wait-state write
        issue(1, 1'b1, AW'(BASE3 + 7), 32'h77777777, 4'hF);
        drive(1, 1'b1, AW'(BASE3 + 7), 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_en[1] = 1'b0;
        #1;
        chk1("t6_stall_rst", rsp_stall[1], 1'b0);
        chk1("t6_valid_rst", rsp_valid[1], 1'b0);
        chk("t6_rdata_rst", rsp_rdata[1], 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 1'b0, AW'(BASE3 + 7), 32'h0, 4'h0);
        chk1("t6_valid_after", rsp_valid[1], 1'b1);
        chk("t6_word_kept", rsp_rdata[1], 32'h77777777);

        // Randomized traffic over a preloaded 16-word window (plus aliases at +DEPTH)
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) issue(d, 1'b1, AW'(baseof(d) + i), $urandom, 4'hF);
        end
        fork
            rand_run(0, 400);
            rand_run(1, 150);
        join
        repeat (6) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
